// File: rtl/program_sequencer_pkg.sv
// Shared types and constants for the program sequencer and its instruction decoder.
package program_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_JUMP  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Low two bits of the 1110_00cc opcode map straight onto this encoding.
    typedef enum logic [1:0] {
        COND_ALWAYS = 2'd0,
        COND_NZ     = 2'd1,
        COND_Z      = 2'd2,
        COND_NEVER  = 2'd3
    } jump_cond_t;

    localparam logic [3:0] SRC_X0     = 4'd0;
    localparam logic [3:0] SRC_DM     = 4'd7;
    localparam logic [3:0] SRC_NIBBLE = 4'd8;
    localparam logic [3:0] SRC_PINS   = 4'd9;

    localparam int EN_R  = 4;
    localparam int EN_I  = 6;
    localparam int EN_DM = 7;
    localparam int EN_O  = 8;

    localparam logic [2:0] DST_I  = 3'd6;
    localparam logic [2:0] DST_DM = 3'd7;
    localparam logic [2:0] DST_O  = 3'd4;

    // Destination field -> one-hot reg_en; code 4 selects o_reg instead of r.
    function automatic logic [8:0] dest_enable(input logic [2:0] dst);
        logic [8:0] en;
        en = '0;
        if (dst == DST_O)
            en[EN_O] = 1'b1;
        else
            en[dst] = 1'b1;
        return en;
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Program-memory bus and computational-unit control bundle driven by the sequencer.
interface program_sequencer_if #(
    parameter int PC_WIDTH = 8
) ();
    logic [PC_WIDTH-1:0] pm_addr;
    logic [7:0]          pm_data;
    logic                r_eq_0;
    logic [PC_WIDTH-1:0] pc;
    logic [7:0]          ir;
    logic [3:0]          source_sel;
    logic [8:0]          reg_en;
    logic                i_sel;
    logic                x_sel;
    logic                y_sel;
    logic [3:0]          nibble_ir;
    logic                halted;

    modport master (
        input  pm_data, r_eq_0,
        output pm_addr, pc, ir, source_sel, reg_en, i_sel, x_sel, y_sel, nibble_ir, halted
    );

    modport slave (
        output pm_data, r_eq_0,
        input  pm_addr, pc, ir, source_sel, reg_en, i_sel, x_sel, y_sel, nibble_ir, halted
    );
endinterface

// File: rtl/program_decoder.sv
// Purely combinational instruction decoder: ir -> datapath controls and jump/halt flags.
module program_decoder
    import program_sequencer_pkg::*;
(
    input  logic [7:0] ir,
    output logic [3:0] source_sel,
    output logic [8:0] reg_en,
    output logic       i_sel,
    output logic       x_sel,
    output logic       y_sel,
    output logic [3:0] nibble_ir,
    output logic       is_jump,
    output jump_cond_t jump_cond,
    output logic       is_halt
);

    logic [2:0] mv_dst;
    logic [2:0] mv_src;

    assign mv_dst = ir[5:3];
    assign mv_src = ir[2:0];

    always_comb begin
        source_sel = '0;
        reg_en     = '0;
        i_sel      = 1'b0;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        nibble_ir  = '0;
        is_jump    = 1'b0;
        jump_cond  = COND_NEVER;
        is_halt    = 1'b0;

        casez (ir)
            8'b0???_????: begin
                source_sel = SRC_NIBBLE;
                nibble_ir  = ir[3:0];
                reg_en     = dest_enable(ir[6:4]);
                // A dm write walks the dm pointer forward.
                if (ir[6:4] == DST_DM) begin
                    reg_en[EN_I] = 1'b1;
                    i_sel        = 1'b1;
                end
            end
            8'b10??_????: begin
                source_sel = (mv_dst == mv_src) ? SRC_PINS : {1'b0, mv_src};
                reg_en     = dest_enable(mv_dst);
                // Any dm access post-increments i unless i itself is the target.
                if ((((mv_src == DST_DM) && (mv_dst != DST_DM)) || (mv_dst == DST_DM))
                        && (mv_dst != DST_I)) begin
                    reg_en[EN_I] = 1'b1;
                    i_sel        = 1'b1;
                end
            end
            8'b110?_????: begin
                reg_en[EN_R] = 1'b1;
                x_sel        = ir[4];
                y_sel        = ir[3];
                nibble_ir    = ir[3:0];
                source_sel   = SRC_X0;
            end
            8'b1110_00??: begin
                if (ir[1:0] == 2'b11) begin
                    is_halt = 1'b1;
                end else begin
                    is_jump   = 1'b1;
                    jump_cond = jump_cond_t'(ir[1:0]);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/program_sequencer.sv
// Fetch/exec/jump/halt sequencer: owns pc and ir and gates decoded controls to the EXEC cycle.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int PC_WIDTH = 8,
    parameter int RESET_PC = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    program_sequencer_if.master  bus
);

    state_t              state_reg, state_next;
    logic [PC_WIDTH-1:0] pc_reg, pc_next;
    logic [7:0]          ir_reg, ir_next;

    logic [3:0]  dec_source_sel;
    logic [8:0]  dec_reg_en;
    logic        dec_i_sel;
    logic        dec_x_sel;
    logic        dec_y_sel;
    logic [3:0]  dec_nibble_ir;
    logic        dec_is_jump;
    jump_cond_t  dec_jump_cond;
    logic        dec_is_halt;
    logic        jump_taken;
    logic        in_exec;

    program_decoder u_decoder (
        .ir         (ir_reg),
        .source_sel (dec_source_sel),
        .reg_en     (dec_reg_en),
        .i_sel      (dec_i_sel),
        .x_sel      (dec_x_sel),
        .y_sel      (dec_y_sel),
        .nibble_ir  (dec_nibble_ir),
        .is_jump    (dec_is_jump),
        .jump_cond  (dec_jump_cond),
        .is_halt    (dec_is_halt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_FETCH;
            pc_reg    <= PC_WIDTH'(RESET_PC);
            ir_reg    <= 8'hFF;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
        end
    end

    // ir still holds the jump opcode during JUMP, so the decoder supplies the condition.
    always_comb begin
        jump_taken = 1'b0;
        case (dec_jump_cond)
            COND_ALWAYS: jump_taken = 1'b1;
            COND_NZ:     jump_taken = ~bus.r_eq_0;
            COND_Z:      jump_taken = bus.r_eq_0;
            default:     jump_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        case (state_reg)
            ST_FETCH: begin
                ir_next    = bus.pm_data;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                pc_next = pc_reg + PC_WIDTH'(1);
                if (dec_is_jump)
                    state_next = ST_JUMP;
                else if (dec_is_halt)
                    state_next = ST_HALT;
                else
                    state_next = ST_FETCH;
            end
            ST_JUMP: begin
                pc_next    = jump_taken ? PC_WIDTH'(bus.pm_data) : pc_reg + PC_WIDTH'(1);
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    assign in_exec = (state_reg == ST_EXEC);

    assign bus.pm_addr    = pc_reg;
    assign bus.pc         = pc_reg;
    assign bus.ir         = ir_reg;
    assign bus.source_sel = in_exec ? dec_source_sel : '0;
    assign bus.reg_en     = in_exec ? dec_reg_en     : '0;
    assign bus.i_sel      = in_exec & dec_i_sel;
    assign bus.x_sel      = in_exec & dec_x_sel;
    assign bus.y_sel      = in_exec & dec_y_sel;
    assign bus.nibble_ir  = in_exec ? dec_nibble_ir  : '0;
    assign bus.halted     = (state_reg == ST_HALT);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed and random program runs checked against an instruction-level reference model.
module tb_program_sequencer;

    typedef struct {
        int src;
        int en;
        int isel;
        int xsel;
        int ysel;
        int nib;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       r_eq_0 = 1'b0;
    logic [7:0] pm [256];
    logic [7:0] pc_m;
    int         checks = 0;
    int         errors = 0;

    program_sequencer_if #(.PC_WIDTH(8)) bus ();

    program_sequencer #(.PC_WIDTH(8), .RESET_PC(0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.pm_data = pm[bus.pm_addr];
    assign bus.r_eq_0  = r_eq_0;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural meaning of each opcode, derived from the instruction-set fields.
    function automatic ctl_t model_ctl(input int op);
        ctl_t c;
        int   dst_bit [8];
        int   d;
        int   s;
        dst_bit = '{0, 1, 2, 3, 8, 5, 6, 7};
        c = '{0, 0, 0, 0, 0, 0};
        d = -1;
        s = -1;
        if (op < 'h80) begin
            d     = op / 16;
            c.src = 8;
            c.nib = op % 16;
        end else if (op < 'hC0) begin
            d     = (op / 8) % 8;
            s     = op % 8;
            c.src = (d == s) ? 9 : s;
        end else if (op < 'hE0) begin
            c.en   = 16;
            c.xsel = (op / 16) % 2;
            c.ysel = (op / 8) % 2;
            c.nib  = op % 16;
        end
        if (d >= 0) begin
            c.en = 1 << dst_bit[d];
            if ((s == 7 || d == 7) && d != 6) begin
                c.en  = c.en + 64;
                c.isel = 1;
            end
        end
        return c;
    endfunction

    // Entered anywhere inside a FETCH cycle; leaves in the FETCH of the next instruction.
    task automatic run_instr(input bit z);
        int   op;
        int   tgt;
        bit   taken;
        ctl_t c;
        op = int'(pm[pc_m]);
        c  = model_ctl(op);
        check("fetch_pc", bus.pc, pc_m);
        check("fetch_en", bus.reg_en, 0);
        tick();
        check("exec_ir", bus.ir, op);
        check("exec_src", bus.source_sel, c.src);
        check("exec_en", bus.reg_en, c.en);
        check("exec_isel", bus.i_sel, c.isel);
        check("exec_xsel", bus.x_sel, c.xsel);
        check("exec_ysel", bus.y_sel, c.ysel);
        check("exec_nib", bus.nibble_ir, c.nib);
        check("exec_halted", bus.halted, 0);
        tick();
        if (op >= 'hE0 && op <= 'hE2) begin
            r_eq_0 = z;
            tgt    = int'(pm[8'(pc_m + 8'd1)]);
            taken  = (op == 'hE0) || (op == 'hE1 && !z) || (op == 'hE2 && z);
            check("jump_addr", bus.pm_addr, 8'(pc_m + 8'd1));
            check("jump_en", bus.reg_en, 0);
            check("jump_src", bus.source_sel, 0);
            tick();
            $display("instr pc=%02h op=%02h z=%0d taken=%0d", pc_m, op, z, taken);
            pc_m = taken ? 8'(tgt) : 8'(pc_m + 8'd2);
        end else if (op == 'hE3) begin
            $display("instr pc=%02h op=%02h halt", pc_m, op);
            pc_m = 8'(pc_m + 8'd1);
            for (int k = 0; k < 10; k++) begin
                check("halt_flag", bus.halted, 1);
                check("halt_en", bus.reg_en, 0);
                check("halt_pc", bus.pc, pc_m);
                tick();
            end
        end else begin
            $display("instr pc=%02h op=%02h", pc_m, op);
            pc_m = 8'(pc_m + 8'd1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        pc_m = 8'h00;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) pm[i] = 8'hF0;
        pm[8'h00] = 8'h05; pm[8'h01] = 8'hC2; pm[8'h02] = 8'hDA;
        pm[8'h03] = 8'hE2; pm[8'h04] = 8'h20;
        pm[8'h05] = 8'hE1; pm[8'h06] = 8'h30;
        pm[8'h20] = 8'hBF; pm[8'h21] = 8'hB7;
        pm[8'h22] = 8'hE1; pm[8'h23] = 8'h40;
        pm[8'h24] = 8'hE0; pm[8'h25] = 8'hFE;
        pm[8'h30] = 8'hE3;

        tick();
        tick();
        check("rst_pc", bus.pc, 0);
        check("rst_ir", bus.ir, 8'hFF);
        check("rst_en", bus.reg_en, 0);
        check("rst_src", bus.source_sel, 0);
        check("rst_halted", bus.halted, 0);
        @(negedge clk);
        reset_n = 1'b1;
        pc_m = 8'h00;

        // 00..03 (JZ taken) -> 20 BF, 21 B7, 22 JNZ not taken -> 24 JMP FE -> FE, FF wrap -> 00
        for (int i = 0; i < 3; i++) run_instr(1'b0);
        run_instr(1'b1);
        check("jz_taken_pc", pc_m, 8'h20);
        run_instr(1'b0);
        run_instr(1'b0);
        run_instr(1'b1);
        run_instr(1'b0);
        run_instr(1'b0);
        run_instr(1'b0);
        check("wrap_pc", bus.pc, 8'h00);
        // Second pass: JZ not taken -> 05, JNZ taken -> 30 HALT
        for (int i = 0; i < 3; i++) run_instr(1'b0);
        run_instr(1'b0);
        check("jz_fall_pc", bus.pc, 8'h05);
        run_instr(1'b0);
        run_instr(1'b0);

        // Asynchronous reset landing in the middle of a JUMP cycle
        do_reset();
        for (int i = 0; i < 3; i++) run_instr(1'b0);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("midrst_pc", bus.pc, 0);
        check("midrst_ir", bus.ir, 8'hFF);
        check("midrst_en", bus.reg_en, 0);
        check("midrst_src", bus.source_sel, 0);
        check("midrst_halted", bus.halted, 0);
        @(negedge clk);
        reset_n = 1'b1;
        pc_m = 8'h00;
        run_instr(1'b0);

        // Random programs (HALT excluded so the walk keeps going)
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 256; i++) begin
                pm[i] = 8'($urandom_range(0, 255));
                if (pm[i] == 8'hE3) pm[i] = 8'hE0;
            end
            do_reset();
            for (int n = 0; n < 120; n++) run_instr(1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
